seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed 7-segment display driver: holds DIGITS 4-bit codes and scans them onto a shared segment bus with one anode enable per digit. It is the clocked successor to the single-digit BCD decoder. It adds multi-digit scanning, hex mode, leading-zero blanking, per-digit decimal points, anti-ghost blanking and tear-free frame-synchronous updates. It sits between the datapath (counters, BCD converters) and the board display pins.

---
 rtl/seg7_scan_driver_pkg.sv | 48 ++++
 rtl/seg7_scan_driver_glyph_decode.sv | 16 +
 rtl/seg7_scan_driver.sv | 150 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared glyph definitions for the 7-segment scan driver.
// Segment bit order: seg[6:0] = {a,b,c,d,e,f,g}, 1 = lit (before pin polarity).
package seg7_scan_driver_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Codes 10-15 only produce letters when hex display is enabled.
    function automatic logic [6:0] glyph_of(input logic [3:0] code, input logic hex_en);
        logic [6:0] g;
        g = SEG_BLANK;
        case (code)
            4'h0: g = SEG_0;
            4'h1: g = SEG_1;
            4'h2: g = SEG_2;
            4'h3: g = SEG_3;
            4'h4: g = SEG_4;
            4'h5: g = SEG_5;
            4'h6: g = SEG_6;
            4'h7: g = SEG_7;
            4'h8: g = SEG_8;
            4'h9: g = SEG_9;
            4'hA: g = hex_en ? SEG_A : SEG_BLANK;
            4'hB: g = hex_en ? SEG_B : SEG_BLANK;
            4'hC: g = hex_en ? SEG_C : SEG_BLANK;
            4'hD: g = hex_en ? SEG_D : SEG_BLANK;
            4'hE: g = hex_en ? SEG_E : SEG_BLANK;
            4'hF: g = hex_en ? SEG_F : SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_glyph_decode.sv
// Combinational glyph decoder for the currently scanned digit.
module seg7_glyph_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_en,
    input  logic       blank,
    output logic [6:0] glyph
);

    // Blanking overrides the code; otherwise look up the glyph.
    always_comb begin
        glyph = blank ? SEG_BLANK : glyph_of(code, hex_en);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: prescaled digit scan, frame-synchronous
// display updates through a staging register, leading-zero blanking and
// anti-ghost anode blanking at the start of every slot.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int PRESCALE       = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter int HEX_EN         = 0,
    parameter int LZ_BLANK       = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    input  logic [DIGITS-1:0]     dp_in,
    output logic                  ready,
    output logic                  frame_tick,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0]     PRE_LAST   = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]     PRE_PENULT = PW'(PRESCALE - 2);
    localparam logic [PW-1:0]     PRE_BLANK  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic              SEG_INV    = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] AN_INV     = {DIGITS{AN_ACTIVE_LOW != 0}};
    localparam logic              HEX_ON     = (HEX_EN != 0);
    localparam logic              LZ_ON      = (LZ_BLANK != 0);

    logic [PW-1:0]       pre;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] stage_code;
    logic [4*DIGITS-1:0] disp_code;
    logic [DIGITS-1:0]   stage_dp;
    logic [DIGITS-1:0]   disp_dp;
    logic                pending;
    logic                pending_next;
    logic                commit;
    logic                accept;

    logic                slot_end;
    logic                frame_end;
    logic                frame_next;
    logic [DIGITS-1:0]   lz_mask;
    logic                upper_zero;
    logic [DIGITS-1:0]   an_sel;
    logic [3:0]          cur_code;
    logic [6:0]          cur_glyph;

    assign slot_end   = (pre == PRE_LAST);
    assign frame_end  = slot_end && (idx == IDX_LAST);
    // Registered frame_tick must line up with the boundary cycle, so it is
    // loaded one cycle ahead from the state that precedes the boundary.
    assign frame_next = (pre == PRE_PENULT) && (idx == IDX_LAST);

    assign commit = frame_end && pending;
    assign accept = load && !pending;

    // Next value of the pending flag; ready is its registered complement.
    always_comb begin
        pending_next = pending;
        if (commit) begin
            pending_next = 1'b0;
        end else if (accept) begin
            pending_next = 1'b1;
        end
    end

    // Leading-zero mask: walk down from the top digit while all seen are zero.
    always_comb begin
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (disp_code[4*i +: 4] == 4'd0);
            if (i != 0) begin
                lz_mask[i] = LZ_ON && upper_zero;
            end
        end
    end

    // Anode select for the current slot, all off during the blank window.
    always_comb begin
        an_sel = '0;
        if (pre >= PRE_BLANK) begin
            an_sel[idx] = 1'b1;
        end
    end

    assign cur_code = disp_code[4*idx +: 4];

    seg7_glyph_decode u_decode (
        .code   (cur_code),
        .hex_en (HEX_ON),
        .blank  (lz_mask[idx]),
        .glyph  (cur_glyph)
    );

    // Scan counters, staging handshake and frame-boundary commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre        <= '0;
            idx        <= '0;
            stage_code <= '0;
            stage_dp   <= '0;
            disp_code  <= '0;
            disp_dp    <= '0;
            pending    <= 1'b0;
        end else begin
            pre <= slot_end ? '0 : pre + 1'b1;
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            if (commit) begin
                disp_code <= stage_code;
                disp_dp   <= stage_dp;
            end else if (accept) begin
                stage_code <= din;
                stage_dp   <= dp_in;
            end
            pending <= pending_next;
        end
    end

    // Output registers with pin polarity applied.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg        <= {7{SEG_INV}};
            dp         <= SEG_INV;
            an         <= AN_INV;
            frame_tick <= 1'b0;
            ready      <= 1'b1;
        end else begin
            seg        <= cur_glyph ^ {7{SEG_INV}};
            dp         <= disp_dp[idx] ^ SEG_INV;
            an         <= an_sel ^ AN_INV;
            frame_tick <= frame_next;
            ready      <= !pending_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: three instances share stimulus
// (decimal mode, hex mode, inverted pin polarity), DIGITS=4, PRESCALE=4,
// BLANK_CYCLES=1.
module tb_seg7_scan_driver;

    localparam logic [6:0] G0 = 7'b1111110;
    localparam logic [6:0] G1 = 7'b0110000;
    localparam logic [6:0] G2 = 7'b1101101;
    localparam logic [6:0] G3 = 7'b1111001;
    localparam logic [6:0] G4 = 7'b0110011;
    localparam logic [6:0] G5 = 7'b1011011;
    localparam logic [6:0] G7 = 7'b1110000;
    localparam logic [6:0] G8 = 7'b1111111;
    localparam logic [6:0] G9 = 7'b1111011;
    localparam logic [6:0] GA = 7'b1110111;
    localparam logic [6:0] GC = 7'b1001110;
    localparam logic [6:0] GF = 7'b1000111;
    localparam logic [6:0] GN = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] din = 16'h0;
    logic [3:0]  dp_in = 4'h0;

    logic        ready0, tick0, dp0;
    logic [6:0]  seg0;
    logic [3:0]  an0;
    logic        ready1, tick1, dp1;
    logic [6:0]  seg1;
    logic [3:0]  an1;
    logic        ready2, tick2, dp2;
    logic [6:0]  seg2;
    logic [3:0]  an2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1), .HEX_EN(0),
                       .LZ_BLANK(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) u0 (
        .clk(clk), .rst_n(rst_n), .load(load), .din(din), .dp_in(dp_in),
        .ready(ready0), .frame_tick(tick0), .seg(seg0), .dp(dp0), .an(an0));

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1), .HEX_EN(1),
                       .LZ_BLANK(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) u1 (
        .clk(clk), .rst_n(rst_n), .load(load), .din(din), .dp_in(dp_in),
        .ready(ready1), .frame_tick(tick1), .seg(seg1), .dp(dp1), .an(an1));

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1), .HEX_EN(0),
                       .LZ_BLANK(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(0)) u2 (
        .clk(clk), .rst_n(rst_n), .load(load), .din(din), .dp_in(dp_in),
        .ready(ready2), .frame_tick(tick2), .seg(seg2), .dp(dp2), .an(an2));

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until frame_tick is seen on u0, bounded to a little over two frames.
    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (tick0 === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Load a value, release load, then run to the commit edge.
    task automatic load_and_commit(input logic [15:0] code, input logic [3:0] dps, output bit ok);
        din   = code;
        dp_in = dps;
        load  = 1'b1;
        step();
        load  = 1'b0;
        wait_tick(ok);
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        total++; if (an0 !== 4'b1111) $display("FAIL reset_an0 got %b exp 1111", an0); else passed++;
        total++; if (seg0 !== 7'b0000000) $display("FAIL reset_seg0 got %b exp 0000000", seg0); else passed++;
        total++; if (dp0 !== 1'b0) $display("FAIL reset_dp0 got %b exp 0", dp0); else passed++;
        total++; if (ready0 !== 1'b1) $display("FAIL reset_ready0 got %b exp 1", ready0); else passed++;
        total++; if (tick0 !== 1'b0) $display("FAIL reset_tick0 got %b exp 0", tick0); else passed++;
        total++; if ({ready1, tick1, an1} !== 6'b10_1111) $display("FAIL reset_u1 got %b exp 101111", {ready1, tick1, an1}); else passed++;
        total++; if (an2 !== 4'b0000) $display("FAIL reset_an2 got %b exp 0000", an2); else passed++;
        total++; if ({seg2, dp2} !== 8'hFF) $display("FAIL reset_seg2 got %b exp 11111111", {seg2, dp2}); else passed++;
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an;
        bit ok;
        int pos, d;
        exp_seg[0] = G4; exp_seg[1] = G3; exp_seg[2] = G2; exp_seg[3] = G1;
        rst_n = 1'b1;
        din   = 16'h1234;
        dp_in = 4'h0;
        load  = 1'b1;
        step();
        load  = 1'b0;
        total++; if (ready0 !== 1'b0) $display("FAIL scan_ready_low got %b exp 0", ready0); else passed++;
        wait_tick(ok);
        total++; if (!ok) $display("FAIL scan_tick_timeout got none exp frame_tick"); else passed++;
        total++; if (ready0 !== 1'b0) $display("FAIL scan_ready_at_commit got %b exp 0", ready0); else passed++;
        step();
        total++; if (ready0 !== 1'b1) $display("FAIL scan_ready_after_commit got %b exp 1", ready0); else passed++;
        for (int j = 1; j <= 16; j++) begin
            step();
            pos = (j - 1) % 4;
            d   = (j - 1) / 4;
            exp_an = 4'b0001 << d;
            exp_an = (pos == 0) ? 4'b1111 : ~exp_an;
            total++; if (an0 !== exp_an) $display("FAIL scan_an j=%0d got %b exp %b", j, an0, exp_an); else passed++;
            total++; if (seg0 !== exp_seg[d]) $display("FAIL scan_seg j=%0d got %b exp %b", j, seg0, exp_seg[d]); else passed++;
            total++; if (tick0 !== (j == 15)) $display("FAIL scan_tick j=%0d got %b exp %b", j, tick0, (j == 15)); else passed++;
        end
    endtask

    task automatic test_handshake();
        logic [6:0] exp_seg [4];
        bit ok;
        exp_seg[0] = G9; exp_seg[1] = GN; exp_seg[2] = GN; exp_seg[3] = GN;
        din   = 16'h0009;
        dp_in = 4'h0;
        load  = 1'b1;
        step();
        din   = 16'h0005;
        step();
        load  = 1'b0;
        total++; if (ready0 !== 1'b0) $display("FAIL hs_ready_pending got %b exp 0", ready0); else passed++;
        wait_tick(ok);
        total++; if (!ok) $display("FAIL hs_tick_timeout got none exp frame_tick"); else passed++;
        total++; if (ready0 !== 1'b0) $display("FAIL hs_ready_commit got %b exp 0", ready0); else passed++;
        step();
        total++; if (ready0 !== 1'b1) $display("FAIL hs_ready_rise got %b exp 1", ready0); else passed++;
        for (int j = 1; j <= 16; j++) begin
            step();
            if ((j - 1) % 4 == 1) begin
                total++; if (seg0 !== exp_seg[(j - 1) / 4]) $display("FAIL hs_seg digit=%0d got %b exp %b", (j - 1) / 4, seg0, exp_seg[(j - 1) / 4]); else passed++;
            end
        end
    endtask

    task automatic test_lz();
        logic [6:0] exp_seg [4];
        logic [3:0] exp_dp;
        bit ok;
        exp_seg[0] = G0; exp_seg[1] = G7; exp_seg[2] = GN; exp_seg[3] = GN;
        exp_dp = 4'b1000;
        load_and_commit(16'h0070, 4'b1000, ok);
        total++; if (!ok) $display("FAIL lz_tick_timeout got none exp frame_tick"); else passed++;
        for (int j = 1; j <= 16; j++) begin
            step();
            if ((j - 1) % 4 == 1) begin
                total++; if (seg0 !== exp_seg[(j - 1) / 4]) $display("FAIL lz_seg digit=%0d got %b exp %b", (j - 1) / 4, seg0, exp_seg[(j - 1) / 4]); else passed++;
                total++; if (dp0 !== exp_dp[(j - 1) / 4]) $display("FAIL lz_dp digit=%0d got %b exp %b", (j - 1) / 4, dp0, exp_dp[(j - 1) / 4]); else passed++;
            end
        end
    endtask

    task automatic test_hex();
        logic [6:0] exp0 [4];
        logic [6:0] exp1 [4];
        bit ok;
        exp0[0] = GN; exp0[1] = G0; exp0[2] = GN; exp0[3] = GN;
        exp1[0] = GC; exp1[1] = G0; exp1[2] = GF; exp1[3] = GA;
        load_and_commit(16'hAF0C, 4'b0000, ok);
        total++; if (!ok) $display("FAIL hex_tick_timeout got none exp frame_tick"); else passed++;
        for (int j = 1; j <= 16; j++) begin
            step();
            if ((j - 1) % 4 == 1) begin
                total++; if (seg0 !== exp0[(j - 1) / 4]) $display("FAIL hex_off_seg digit=%0d got %b exp %b", (j - 1) / 4, seg0, exp0[(j - 1) / 4]); else passed++;
                total++; if (seg1 !== exp1[(j - 1) / 4]) $display("FAIL hex_on_seg digit=%0d got %b exp %b", (j - 1) / 4, seg1, exp1[(j - 1) / 4]); else passed++;
                total++; if (dp1 !== 1'b0) $display("FAIL hex_on_dp digit=%0d got %b exp 0", (j - 1) / 4, dp1); else passed++;
            end
        end
    endtask

    task automatic test_polarity();
        bit ok;
        load_and_commit(16'h0008, 4'b0000, ok);
        total++; if (!ok) $display("FAIL pol_tick_timeout got none exp frame_tick"); else passed++;
        for (int j = 1; j <= 16; j++) begin
            step();
            if (j == 2) begin
                total++; if (seg2 !== 7'b0000000) $display("FAIL pol_seg_d0 got %b exp 0000000", seg2); else passed++;
                total++; if (an2 !== 4'b0001) $display("FAIL pol_an_d0 got %b exp 0001", an2); else passed++;
                total++; if (dp2 !== 1'b1) $display("FAIL pol_dp_d0 got %b exp 1", dp2); else passed++;
            end
            if (j == 5) begin
                total++; if (an2 !== 4'b0000) $display("FAIL pol_an_blankwin got %b exp 0000", an2); else passed++;
            end
            if (j == 6) begin
                total++; if (seg2 !== 7'b1111111) $display("FAIL pol_seg_d1 got %b exp 1111111", seg2); else passed++;
                total++; if (an2 !== 4'b0010) $display("FAIL pol_an_d1 got %b exp 0010", an2); else passed++;
            end
        end
    endtask

    // Load accepted on the boundary cycle itself commits one frame later.
    task automatic test_back_to_back();
        bit ok;
        wait_tick(ok);
        total++; if (!ok) $display("FAIL b2b_tick1_timeout got none exp frame_tick"); else passed++;
        din   = 16'h0002;
        dp_in = 4'h0;
        load  = 1'b1;
        step();
        load  = 1'b0;
        total++; if (ready0 !== 1'b0) $display("FAIL b2b_ready_low got %b exp 0", ready0); else passed++;
        step();
        step();
        total++; if (seg0 !== G8) $display("FAIL b2b_old_value got %b exp %b", seg0, G8); else passed++;
        wait_tick(ok);
        total++; if (!ok) $display("FAIL b2b_tick2_timeout got none exp frame_tick"); else passed++;
        total++; if (ready0 !== 1'b0) $display("FAIL b2b_ready_commit got %b exp 0", ready0); else passed++;
        step();
        total++; if (ready0 !== 1'b1) $display("FAIL b2b_ready_rise got %b exp 1", ready0); else passed++;
        step();
        step();
        total++; if (seg0 !== G2) $display("FAIL b2b_new_value got %b exp %b", seg0, G2); else passed++;
        total++; if (an0 !== 4'b1110) $display("FAIL b2b_an got %b exp 1110", an0); else passed++;
    endtask

    task automatic test_reset_pending();
        bit bad_seg, bad_ready;
        din   = 16'h5555;
        dp_in = 4'b1111;
        load  = 1'b1;
        step();
        load  = 1'b0;
        total++; if (ready0 !== 1'b0) $display("FAIL rp_ready_pending got %b exp 0", ready0); else passed++;
        step();
        rst_n = 1'b0;
        repeat (3) step();
        total++; if (an0 !== 4'b1111) $display("FAIL rp_an got %b exp 1111", an0); else passed++;
        total++; if (seg0 !== 7'b0000000) $display("FAIL rp_seg got %b exp 0000000", seg0); else passed++;
        total++; if (ready0 !== 1'b1) $display("FAIL rp_ready got %b exp 1", ready0); else passed++;
        total++; if (tick0 !== 1'b0) $display("FAIL rp_tick got %b exp 0", tick0); else passed++;
        rst_n = 1'b1;
        bad_seg   = 1'b0;
        bad_ready = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (seg0 === G5 || dp0 !== 1'b0) bad_seg = 1'b1;
            if (ready0 !== 1'b1) bad_ready = 1'b1;
            if (n == 2) begin
                total++; if ({an0, seg0} !== {4'b1110, G0}) $display("FAIL rp_first_digit got %b exp %b", {an0, seg0}, {4'b1110, G0}); else passed++;
            end
        end
        total++; if (bad_seg !== 1'b0) $display("FAIL rp_staged_shown got %b exp 0", bad_seg); else passed++;
        total++; if (bad_ready !== 1'b0) $display("FAIL rp_ready_stable got %b exp 0", bad_ready); else passed++;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_handshake();
        test_lz();
        test_hex();
        test_polarity();
        test_back_to_back();
        test_reset_pending();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
